dis_pal_vst_arbiter: RTL and testbench

Two-input Avalon-ST video arbiter that sits in front of the PAL display write path. It selects one of two upstream video sources and forwards whole packets to the single display stream. Source changes happen only at packet boundaries. A watchdog fails over to the other source when the selected one stops producing frames.

---
 rtl/dis_pal_pkg.sv | 6 +
 rtl/dis_pal_wdt.sv | 23 ++
 rtl/dis_pal_vst_arbiter.sv | 82 ++++++++
 tb/tb_dis_pal_vst_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dis_pal_pkg.sv
// dis_pal_pkg: shared constants and FSM encodings for the dis_pal display blocks
package dis_pal_pkg;
    // Two PAL frame periods at the video clock
    localparam logic [23:0] TIMEOUT_DEFAULT = 24'd4_000_000;
    typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;
endpackage

// File: rtl/dis_pal_wdt.sv
// dis_pal_wdt: saturating watchdog counter, flags timeout at TIMEOUT-1
//   vst_clk, vst_rst_n : clock, async active-low reset
//   clr                : zero the counter
//   en                 : count enable
//   timeout            : counter has reached TIMEOUT-1
module dis_pal_wdt
    import dis_pal_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic vst_clk,
    input  logic vst_rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    logic [23:0] wdt;
    assign timeout = wdt == TIMEOUT - 24'd1;
    always_ff @(posedge vst_clk or negedge vst_rst_n)
        if (!vst_rst_n) wdt <= '0;
        else if (clr) wdt <= '0;
        else if (en && !timeout) wdt <= wdt + 24'd1;
endmodule

// File: rtl/dis_pal_vst_arbiter.sv
// dis_pal_vst_arbiter: two-source Avalon-ST video arbiter with packet-boundary switching and watchdog failover
//   vst_clk, vst_rst_n         : clock, async active-low reset
//   s0_*/s1_*                  : upstream sources (data, valid, ready, sop, eop)
//   vst_*                      : forwarded stream to the PAL display write path
//   sel_src                    : software-preferred source
//   cur_src                    : currently granted source
//   in_packet                  : high while forwarding a packet
//   failover                   : set on watchdog timeout, cleared by any sel_src change
module dis_pal_vst_arbiter
    import dis_pal_pkg::*;
#(
    parameter int          DATA_WIDTH  = 10,
    parameter logic [23:0] TIMEOUT     = TIMEOUT_DEFAULT,
    parameter bit          DRAIN_OTHER = 1'b1
) (
    input  logic                  vst_clk,
    input  logic                  vst_rst_n,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic                  s0_startofpacket,
    input  logic                  s0_endofpacket,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic                  s1_startofpacket,
    input  logic                  s1_endofpacket,
    output logic [DATA_WIDTH-1:0] vst_data,
    output logic                  vst_valid,
    input  logic                  vst_ready,
    output logic                  vst_startofpacket,
    output logic                  vst_endofpacket,
    input  logic                  sel_src,
    output logic                  cur_src,
    output logic                  in_packet,
    output logic                  failover
);
    state_t state, state_nx;
    logic run, sel_src_d, g_valid, g_ready, acc, sop_acc, eop_acc, timeout, switch_src;

    always_comb begin
        g_valid           = cur_src ? s1_valid : s0_valid;
        vst_data          = cur_src ? s1_data : s0_data;
        vst_startofpacket = cur_src ? s1_startofpacket : s0_startofpacket;
        vst_endofpacket   = cur_src ? s1_endofpacket : s0_endofpacket;
        // run gates all handshakes so readies stay low until the first edge after reset
        g_ready           = run & ((state == IDLE & !vst_startofpacket) | vst_ready);
        vst_valid         = run & g_valid & (state == PASS | vst_startofpacket);
        s0_ready          = cur_src ? (run & DRAIN_OTHER) : g_ready;
        s1_ready          = cur_src ? g_ready : (run & DRAIN_OTHER);
        acc               = vst_valid & vst_ready;
        sop_acc           = acc & vst_startofpacket;
        eop_acc           = acc & vst_endofpacket;
        switch_src        = state == IDLE & !acc & !failover & (sel_src != cur_src) & !timeout;
        state_nx          = (timeout | eop_acc) ? IDLE : sop_acc ? PASS : state;
        in_packet         = state == PASS;
    end

    always_ff @(posedge vst_clk or negedge vst_rst_n)
        if (!vst_rst_n) begin
            run       <= 1'b0;
            state     <= IDLE;
            cur_src   <= 1'b0;
            failover  <= 1'b0;
            sel_src_d <= 1'b0;
        end else begin
            run       <= 1'b1;
            state     <= state_nx;
            cur_src   <= timeout ? !cur_src : switch_src ? sel_src : cur_src;
            failover  <= timeout | (failover & (sel_src_d == sel_src));
            // holding sel_src_d across a timeout lets a coincident sel_src edge clear failover one cycle later
            sel_src_d <= timeout ? sel_src_d : sel_src;
        end

    dis_pal_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .vst_clk  (vst_clk),
        .vst_rst_n(vst_rst_n),
        .clr      (sop_acc | switch_src | timeout),
        .en       (1'b1),
        .timeout  (timeout)
    );
endmodule

// File: tb/tb_dis_pal_vst_arbiter.sv
// tb_dis_pal_vst_arbiter: randomized phases against a behavioural arbiter model
module tb_dis_pal_vst_arbiter;
    localparam int DW = 10;
    localparam int TO = 1000;

    logic          vst_clk = 1'b0;
    logic          vst_rst_n;
    logic [DW-1:0] s0_data, s1_data, vst_data;
    logic          s0_valid, s0_ready, s0_startofpacket, s0_endofpacket;
    logic          s1_valid, s1_ready, s1_startofpacket, s1_endofpacket;
    logic          vst_valid, vst_ready, vst_startofpacket, vst_endofpacket;
    logic          sel_src, cur_src, in_packet, failover;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 vst_clk = ~vst_clk;

    dis_pal_vst_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(24'(TO)), .DRAIN_OTHER(1'b1)) dut (
        .vst_clk(vst_clk), .vst_rst_n(vst_rst_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s0_startofpacket(s0_startofpacket), .s0_endofpacket(s0_endofpacket),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_startofpacket(s1_startofpacket), .s1_endofpacket(s1_endofpacket),
        .vst_data(vst_data), .vst_valid(vst_valid), .vst_ready(vst_ready),
        .vst_startofpacket(vst_startofpacket), .vst_endofpacket(vst_endofpacket),
        .sel_src(sel_src), .cur_src(cur_src), .in_packet(in_packet), .failover(failover)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model state: granted source, inside a packet, failover flag, cycles since last progress, registered sel
    bit m_cur, m_pkt, m_fail, m_seld, m_run;
    int m_idle;

    task automatic model_reset();
        m_cur = 0; m_pkt = 0; m_fail = 0; m_seld = 0; m_run = 0; m_idle = 0;
    endtask

    typedef struct {int cycles; int vpct; int spct; int epct; int selpct;} phase_t;
    phase_t ph[6] = '{
        '{400, 80, 10, 10, 1},
        '{1100, 0, 0, 0, 0},
        '{30, 80, 10, 10, 20},
        '{60, 90, 5, 0, 0},
        '{1100, 90, 0, 0, 0},
        '{400, 70, 15, 15, 2}
    };

    initial begin
        int cyc = 0;
        bit gv, gs, ge, e_valid, e_rg, acc, tmo, sw;
        logic [DW-1:0] gd;
        model_reset();
        vst_rst_n = 0; sel_src = 0; vst_ready = 1;
        s0_valid = 1; s0_startofpacket = 1; s0_endofpacket = 0; s0_data = '0;
        s1_valid = 1; s1_startofpacket = 1; s1_endofpacket = 0; s1_data = '0;
        #2;
        chk("rst_vst_valid", vst_valid, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_cur_src", cur_src, 0);
        chk("rst_in_packet", in_packet, 0);
        chk("rst_failover", failover, 0);
        #10 vst_rst_n = 1;
        foreach (ph[p]) begin
            for (int i = 0; i < ph[p].cycles; i++) begin
                s0_valid = $urandom_range(99) < ph[p].vpct;
                s0_startofpacket = $urandom_range(99) < ph[p].spct;
                s0_endofpacket = $urandom_range(99) < ph[p].epct;
                s0_data = DW'($urandom);
                s1_valid = $urandom_range(99) < ph[p].vpct;
                s1_startofpacket = $urandom_range(99) < ph[p].spct;
                s1_endofpacket = $urandom_range(99) < ph[p].epct;
                s1_data = DW'($urandom);
                vst_ready = $urandom_range(99) < 70;
                if ($urandom_range(99) < ph[p].selpct) sel_src = ~sel_src;
                if (cyc == 250) begin
                    vst_rst_n = 0;
                    #1;
                    chk("arst_vst_valid", vst_valid, 0);
                    chk("arst_s0_ready", s0_ready, 0);
                    chk("arst_s1_ready", s1_ready, 0);
                    chk("arst_cur_src", cur_src, 0);
                    chk("arst_in_packet", in_packet, 0);
                    chk("arst_failover", failover, 0);
                    model_reset();
                    vst_rst_n = 1;
                    #1;
                end else #2;
                gv = m_cur ? s1_valid : s0_valid;
                gs = m_cur ? s1_startofpacket : s0_startofpacket;
                ge = m_cur ? s1_endofpacket : s0_endofpacket;
                gd = m_cur ? s1_data : s0_data;
                // outside a packet only SOP beats are offered; everything else is swallowed
                e_valid = m_run && gv && (m_pkt || gs);
                e_rg = m_run && ((!m_pkt && !gs) || vst_ready);
                chk("vst_valid", vst_valid, e_valid);
                chk("s0_ready", s0_ready, m_cur ? m_run : e_rg);
                chk("s1_ready", s1_ready, m_cur ? e_rg : m_run);
                chk("cur_src", cur_src, m_cur);
                chk("in_packet", in_packet, m_pkt);
                chk("failover", failover, m_fail);
                if (e_valid) begin
                    chk("vst_data", vst_data, gd);
                    chk("vst_sop", vst_startofpacket, gs);
                    chk("vst_eop", vst_endofpacket, ge);
                end
                acc = e_valid && vst_ready;
                tmo = m_idle == TO - 1;
                sw = !m_pkt && !acc && !m_fail && sel_src != m_cur;
                if (tmo) begin
                    m_cur = !m_cur; m_pkt = 0; m_fail = 1; m_idle = 0;
                end else begin
                    if (acc) m_pkt = ge ? 0 : (gs ? 1 : m_pkt);
                    if (sw) begin
                        m_cur = sel_src; m_idle = 0;
                    end else if (acc && gs) m_idle = 0;
                    else if (m_idle < TO - 1) m_idle++;
                    if (sel_src != m_seld) m_fail = 0;
                    m_seld = sel_src;
                end
                m_run = 1;
                cyc++;
                @(posedge vst_clk);
                #1;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
